// File: rtl/banco_registros_rtc.sv
// banco_registros_rtc: time/alarm/status register bank.
//
// Holds a 15-entry register map and serves single-beat read/write requests
// from two requesters. The RTC refresh engine has fixed priority over the
// user controller. Time and alarm writes are checked for legal BCD ranges.
// Write permissions are enforced per register. The alarm flag (reg 10 bit 0)
// is raised whenever the enabled alarm time matches the current time.
//
// Ports
//   CLK, reset                    clock (rising edge), async active-low reset
//   req_us/wr_us/addr_us/
//   dato_us_in                    user request, held until ack_us
//   dato_us_out/ack_us/err_us     user completion (one-cycle ack, data, error)
//   req_rtc/wr_rtc/addr_rtc/
//   dato_rtc_in                   RTC engine request, held until ack_rtc
//   dato_rtc_out/ack_rtc          RTC completion (one-cycle ack, data)
//   edicion                       user edit mode, blocks RTC writes to regs 1-6
//   alarma                        registered copy of reg 10 bit 0
module banco_registros_rtc #(
  parameter int unsigned N_REG       = 15,
  parameter logic [7:0]  RST_DIA_MES = 8'h01
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       req_us,
  input  logic       wr_us,
  input  logic [3:0] addr_us,
  input  logic [7:0] dato_us_in,
  output logic [7:0] dato_us_out,
  output logic       ack_us,
  output logic       err_us,
  input  logic       req_rtc,
  input  logic       wr_rtc,
  input  logic [3:0] addr_rtc,
  input  logic [7:0] dato_rtc_in,
  output logic [7:0] dato_rtc_out,
  output logic       ack_rtc,
  input  logic       edicion,
  output logic       alarma
);

  typedef enum logic [1:0] {StIdle, StSrvRtc, StSrvUs, StAck} state_e;

  state_e     state_q, state_d;
  logic [7:0] regs_q [16];
  logic [7:0] regs_d [16];
  logic       ack_us_q, ack_us_d;
  logic       ack_rtc_q, ack_rtc_d;
  logic       err_us_q, err_us_d;
  logic [7:0] dato_us_q, dato_us_d;
  logic [7:0] dato_rtc_q, dato_rtc_d;
  logic       alarma_q, alarma_d;

  logic       sel_rtc;
  logic       acc_wr;
  logic [3:0] acc_addr;
  logic [7:0] acc_din;
  logic       addr_ok;
  logic [7:0] rd_val;
  logic       us_wr_ok;
  logic       rtc_wr_ok;
  logic       alarm_match;

  // Range check for BCD-coded time/alarm registers; other registers take any value.
  function automatic logic bcd_ok(input logic [3:0] a, input logic [7:0] v);
    logic dig;
    logic ok;
    dig = (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
    case (a)
      4'd1, 4'd2, 4'd7, 4'd8: ok = dig && (v <= 8'h59);
      4'd3, 4'd9:             ok = dig && (v <= 8'h23);
      4'd4:                   ok = dig && (v >= 8'h01) && (v <= 8'h31);
      4'd5:                   ok = dig && (v >= 8'h01) && (v <= 8'h12);
      4'd6:                   ok = dig;
      default:                ok = 1'b1;
    endcase
    return ok;
  endfunction

  always_comb begin
    state_d    = state_q;
    regs_d     = regs_q;
    ack_us_d   = 1'b0;
    ack_rtc_d  = 1'b0;
    err_us_d   = 1'b0;
    dato_us_d  = 8'h00;
    dato_rtc_d = 8'h00;
    alarma_d   = regs_q[10][0];

    // Both SRV states share one datapath; the state picks the port.
    sel_rtc  = (state_q == StSrvRtc);
    acc_wr   = sel_rtc ? wr_rtc      : wr_us;
    acc_addr = sel_rtc ? addr_rtc    : addr_us;
    acc_din  = sel_rtc ? dato_rtc_in : dato_us_in;

    addr_ok = (acc_addr != 4'd0) && (32'(acc_addr) <= N_REG);
    rd_val  = addr_ok ? regs_q[acc_addr] : 8'h00;

    // Status regs are RTC-owned; user may only clear the alarm flag register.
    us_wr_ok  = addr_ok && bcd_ok(acc_addr, acc_din) && (acc_addr < 4'd13) &&
                !((acc_addr == 4'd10) && (acc_din != 8'h00));
    rtc_wr_ok = addr_ok && bcd_ok(acc_addr, acc_din) &&
                !(edicion && (acc_addr >= 4'd1) && (acc_addr <= 4'd6));

    alarm_match = regs_q[11][0] && (regs_q[1] == regs_q[7]) &&
                  (regs_q[2] == regs_q[8]) && (regs_q[3] == regs_q[9]);

    unique case (state_q)
      StIdle: begin
        if (req_rtc) begin
          state_d = StSrvRtc;
        end else if (req_us) begin
          state_d = StSrvUs;
        end
      end
      StSrvRtc: begin
        state_d   = StAck;
        ack_rtc_d = 1'b1;
        if (acc_wr) begin
          if (rtc_wr_ok) begin
            regs_d[acc_addr] = acc_din;
          end
        end else begin
          dato_rtc_d = rd_val;
        end
      end
      StSrvUs: begin
        state_d  = StAck;
        ack_us_d = 1'b1;
        if (acc_wr) begin
          if (us_wr_ok) begin
            regs_d[acc_addr] = acc_din;
          end else begin
            err_us_d = 1'b1;
          end
        end else begin
          dato_us_d = rd_val;
          err_us_d  = !addr_ok;
        end
      end
      StAck: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Applied after the access so a simultaneous user clear loses to the set.
    if (alarm_match) begin
      regs_d[10][0] = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      ack_us_q   <= 1'b0;
      ack_rtc_q  <= 1'b0;
      err_us_q   <= 1'b0;
      dato_us_q  <= 8'h00;
      dato_rtc_q <= 8'h00;
      alarma_q   <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        regs_q[i] <= ((i == 4) || (i == 5)) ? RST_DIA_MES : 8'h00;
      end
    end else begin
      state_q    <= state_d;
      ack_us_q   <= ack_us_d;
      ack_rtc_q  <= ack_rtc_d;
      err_us_q   <= err_us_d;
      dato_us_q  <= dato_us_d;
      dato_rtc_q <= dato_rtc_d;
      alarma_q   <= alarma_d;
      regs_q     <= regs_d;
    end
  end

  assign dato_us_out  = dato_us_q;
  assign ack_us       = ack_us_q;
  assign err_us       = err_us_q;
  assign dato_rtc_out = dato_rtc_q;
  assign ack_rtc      = ack_rtc_q;
  assign alarma       = alarma_q;

endmodule

// File: tb/tb_banco_registros_rtc.sv
module tb_banco_registros_rtc;

  logic       CLK;
  logic       reset;
  logic       req_us, wr_us, req_rtc, wr_rtc, edicion;
  logic [3:0] addr_us, addr_rtc;
  logic [7:0] dato_us_in, dato_rtc_in;
  logic [7:0] dato_us_out, dato_rtc_out;
  logic       ack_us, err_us, ack_rtc, alarma;

  int n_vec = 0;
  int n_err = 0;

  banco_registros_rtc dut (
    .CLK         (CLK),
    .reset       (reset),
    .req_us      (req_us),
    .wr_us       (wr_us),
    .addr_us     (addr_us),
    .dato_us_in  (dato_us_in),
    .dato_us_out (dato_us_out),
    .ack_us      (ack_us),
    .err_us      (err_us),
    .req_rtc     (req_rtc),
    .wr_rtc      (wr_rtc),
    .addr_rtc    (addr_rtc),
    .dato_rtc_in (dato_rtc_in),
    .dato_rtc_out(dato_rtc_out),
    .ack_rtc     (ack_rtc),
    .edicion     (edicion),
    .alarma      (alarma)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic       rtc;
    logic       wr;
    logic [3:0] addr;
    logic [7:0] din;
    logic       ed;
    logic [7:0] exp_rd;
    logic       exp_err;
  } vec_t;

  vec_t vt[$];

  task automatic add(input logic rtc, input logic wr, input logic [3:0] a, input logic [7:0] d,
                     input logic ed, input logic [7:0] er, input logic ee);
    vec_t v;
    v.rtc = rtc; v.wr = wr; v.addr = a; v.din = d; v.ed = ed; v.exp_rd = er; v.exp_err = ee;
    vt.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // One transaction; returns data/error seen in the ack cycle and the edge count to ack.
  task automatic access(input logic rtc, input logic wr, input logic [3:0] a,
                        input logic [7:0] d, output logic [7:0] rd, output logic er,
                        output int lat);
    @(posedge CLK); #1;
    if (rtc) begin
      req_rtc = 1'b1; wr_rtc = wr; addr_rtc = a; dato_rtc_in = d;
    end else begin
      req_us = 1'b1; wr_us = wr; addr_us = a; dato_us_in = d;
    end
    lat = -1; rd = 8'h00; er = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge CLK); #1;
      if ((rtc ? ack_us : ack_rtc) !== 1'b0) begin
        n_err++;
        $display("FAIL stray_ack: other port acked during access to addr %0d", a);
      end
      if ((rtc ? ack_rtc : ack_us) === 1'b1) begin
        lat = c;
        rd  = rtc ? dato_rtc_out : dato_us_out;
        er  = err_us;
        break;
      end
    end
    req_rtc = 1'b0;
    req_us  = 1'b0;
    if (lat < 0) begin
      n_err++;
      $display("FAIL timeout: no ack for addr %0d, got none, expected ack", a);
    end
  endtask

  task automatic do_chk(input string nm, input logic rtc, input logic wr, input logic [3:0] a,
                        input logic [7:0] d, input logic [7:0] erd, input logic eerr);
    logic [7:0] rd;
    logic       er;
    int         lat;
    access(rtc, wr, a, d, rd, er, lat);
    chk({nm, "_rd"}, 32'(rd), 32'(erd));
    chk({nm, "_err"}, 32'(er), 32'(eerr));
  endtask

  task automatic tick_chk_alarma(input string nm, input logic exp);
    @(posedge CLK); #1;
    chk(nm, 32'(alarma), 32'(exp));
  endtask

  initial begin
    logic [7:0] rd;
    logic       er;
    int         lat;
    int         rtc_cyc, us_cyc;
    logic [7:0] us_rd;

    reset = 1'b0;
    req_us = 0; wr_us = 0; addr_us = 0; dato_us_in = 0;
    req_rtc = 0; wr_rtc = 0; addr_rtc = 0; dato_rtc_in = 0;
    edicion = 0;

    // Directed vectors: rtc, wr, addr, din, edicion, expected read data, expected err
    add(0, 0, 4'd4,  8'h00, 0, 8'h01, 0);
    add(0, 0, 4'd1,  8'h00, 0, 8'h00, 0);
    add(0, 0, 4'd5,  8'h00, 0, 8'h01, 0);
    add(0, 1, 4'd2,  8'h45, 0, 8'h00, 0);
    add(0, 0, 4'd2,  8'h00, 0, 8'h45, 0);
    add(0, 1, 4'd2,  8'h60, 0, 8'h00, 1);
    add(0, 0, 4'd2,  8'h00, 0, 8'h45, 0);
    add(0, 1, 4'd3,  8'h1A, 0, 8'h00, 1);
    add(0, 1, 4'd3,  8'h23, 0, 8'h00, 0);
    add(0, 1, 4'd3,  8'h24, 0, 8'h00, 1);
    add(0, 1, 4'd4,  8'h00, 0, 8'h00, 1);
    add(0, 1, 4'd4,  8'h31, 0, 8'h00, 0);
    add(0, 1, 4'd4,  8'h32, 0, 8'h00, 1);
    add(0, 0, 4'd4,  8'h00, 0, 8'h31, 0);
    add(0, 1, 4'd5,  8'h13, 0, 8'h00, 1);
    add(0, 1, 4'd5,  8'h12, 0, 8'h00, 0);
    add(0, 1, 4'd6,  8'h99, 0, 8'h00, 0);
    add(0, 1, 4'd6,  8'h9A, 0, 8'h00, 1);
    add(0, 0, 4'd6,  8'h00, 0, 8'h99, 0);
    add(0, 0, 4'd0,  8'h00, 0, 8'h00, 1);
    add(0, 1, 4'd0,  8'h55, 0, 8'h00, 1);
    add(1, 1, 4'd1,  8'h30, 1, 8'h00, 0);
    add(1, 0, 4'd1,  8'h00, 1, 8'h00, 0);
    add(1, 1, 4'd13, 8'hA5, 1, 8'h00, 0);
    add(0, 0, 4'd13, 8'h00, 1, 8'hA5, 0);
    add(0, 1, 4'd13, 8'h11, 0, 8'h00, 1);
    add(0, 0, 4'd13, 8'h00, 0, 8'hA5, 0);
    add(1, 1, 4'd1,  8'h30, 0, 8'h00, 0);
    add(1, 0, 4'd1,  8'h00, 0, 8'h30, 0);
    add(1, 1, 4'd1,  8'h5A, 0, 8'h00, 0);
    add(0, 0, 4'd1,  8'h00, 0, 8'h30, 0);
    add(0, 1, 4'd12, 8'h7F, 0, 8'h00, 0);
    add(0, 0, 4'd12, 8'h00, 0, 8'h7F, 0);
    add(0, 1, 4'd10, 8'h00, 0, 8'h00, 0);

    // Reset state
    @(posedge CLK); #1;
    chk("rst_ack_us", 32'(ack_us), 0);
    chk("rst_ack_rtc", 32'(ack_rtc), 0);
    chk("rst_err_us", 32'(err_us), 0);
    chk("rst_dato_us", 32'(dato_us_out), 0);
    chk("rst_dato_rtc", 32'(dato_rtc_out), 0);
    chk("rst_alarma", 32'(alarma), 0);
    @(posedge CLK); #1;
    reset = 1'b1;

    foreach (vt[i]) begin
      edicion = vt[i].ed;
      access(vt[i].rtc, vt[i].wr, vt[i].addr, vt[i].din, rd, er, lat);
      chk($sformatf("v%0d_lat", i), 32'(lat), 2);
      chk($sformatf("v%0d_rd", i), 32'(rd), 32'(vt[i].exp_rd));
      chk($sformatf("v%0d_err", i), 32'(er), 32'(vt[i].exp_err));
    end
    edicion = 1'b0;

    // Simultaneous requests: RTC served first, user three cycles later.
    @(posedge CLK); #1;
    req_us = 1'b1; wr_us = 1'b0; addr_us = 4'd2;
    req_rtc = 1'b1; wr_rtc = 1'b1; addr_rtc = 4'd1; dato_rtc_in = 8'h15;
    rtc_cyc = -1; us_cyc = -1; us_rd = 8'h00;
    for (int c = 1; c <= 15; c++) begin
      @(posedge CLK); #1;
      if (ack_rtc === 1'b1) begin rtc_cyc = c; req_rtc = 1'b0; end
      if (ack_us === 1'b1) begin us_cyc = c; us_rd = dato_us_out; req_us = 1'b0; end
      if (us_cyc > 0 && rtc_cyc > 0) break;
    end
    req_rtc = 1'b0; req_us = 1'b0;
    chk("arb_rtc_cycle", 32'(rtc_cyc), 2);
    chk("arb_us_cycle", 32'(us_cyc), 5);
    chk("arb_us_data", 32'(us_rd), 32'h45);
    do_chk("arb_rtc_written", 0, 0, 4'd1, 8'h00, 8'h15, 0);

    // Alarm: program 00:00:10, enable, then bring the time to match.
    do_chk("al_w7", 0, 1, 4'd7, 8'h10, 8'h00, 0);
    do_chk("al_w8", 0, 1, 4'd8, 8'h00, 8'h00, 0);
    do_chk("al_w9", 0, 1, 4'd9, 8'h00, 8'h00, 0);
    do_chk("al_w11", 0, 1, 4'd11, 8'h01, 8'h00, 0);
    do_chk("al_rtc_min", 1, 1, 4'd2, 8'h00, 8'h00, 0);
    do_chk("al_rtc_hora", 1, 1, 4'd3, 8'h00, 8'h00, 0);
    chk("al_idle", 32'(alarma), 0);
    do_chk("al_rtc_seg", 1, 1, 4'd1, 8'h10, 8'h00, 0);
    chk("al_at_ack", 32'(alarma), 0);
    tick_chk_alarma("al_plus1", 1'b0);
    tick_chk_alarma("al_plus2", 1'b1);
    // Clear while still matching: the set wins.
    do_chk("al_clr_match", 0, 1, 4'd10, 8'h00, 8'h00, 0);
    do_chk("al_rd10_set", 0, 0, 4'd10, 8'h00, 8'h01, 0);
    chk("al_still", 32'(alarma), 1);
    do_chk("al_rtc_seg2", 1, 1, 4'd1, 8'h11, 8'h00, 0);
    do_chk("al_clr", 0, 1, 4'd10, 8'h00, 8'h00, 0);
    tick_chk_alarma("al_cleared", 1'b0);
    do_chk("al_w10_01", 0, 1, 4'd10, 8'h01, 8'h00, 1);
    do_chk("al_rd10_clr", 0, 0, 4'd10, 8'h00, 8'h00, 0);

    // Reset in the middle of a user write.
    @(posedge CLK); #1;
    req_us = 1'b1; wr_us = 1'b1; addr_us = 4'd12; dato_us_in = 8'h33;
    @(posedge CLK); #1;
    reset = 1'b0;
    #1;
    chk("mid_ack_us", 32'(ack_us), 0);
    chk("mid_err_us", 32'(err_us), 0);
    chk("mid_dato_us", 32'(dato_us_out), 0);
    chk("mid_alarma", 32'(alarma), 0);
    for (int c = 0; c < 2; c++) begin
      @(posedge CLK); #1;
      chk($sformatf("mid_noack%0d", c), 32'(ack_us), 0);
    end
    req_us = 1'b0;
    reset = 1'b1;
    do_chk("post_r12", 0, 0, 4'd12, 8'h00, 8'h00, 0);
    do_chk("post_r4", 0, 0, 4'd4, 8'h00, 8'h01, 0);
    do_chk("post_r2", 0, 0, 4'd2, 8'h00, 8'h00, 0);
    do_chk("post_r13", 0, 0, 4'd13, 8'h00, 8'h00, 0);
    do_chk("post_r11", 0, 0, 4'd11, 8'h00, 8'h00, 0);
    chk("post_alarma", 32'(alarma), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/banco_registros_rtc.md
Name: banco_registros_rtc

Overview:
- Responder end of the user-control register protocol: holds the 15-entry time/alarm/status register map and serves read/write requests from the user controller.
- Also serves a second requester, the RTC refresh engine, on an identical port; a fixed-priority arbiter picks between the two.
- Validates BCD ranges on time and alarm writes, enforces per-register write permissions, and raises the alarm flag.

Parameters:
- N_REG, 15, number of implemented registers (addresses 1..N_REG; address 0 unimplemented).
- RST_DIA_MES, 8'h01, reset value of day and month registers.

Ports:
- CLK  input  1  system clock, all logic on rising edge
- reset  input  1  asynchronous, active-low reset
- req_us  input  1  user request, level, held until ack_us
- wr_us  input  1  1 = write, 0 = read; sampled with req_us
- addr_us  input  4  user register address
- dato_us_in  input  8  user write data
- dato_us_out  output  8  user read data, valid in the ack_us cycle
- ack_us  output  1  one-cycle completion pulse to user
- err_us  output  1  valid with ack_us; 1 = access rejected
- req_rtc  input  1  RTC engine request, level, held until ack_rtc
- wr_rtc  input  1  RTC write/read select
- addr_rtc  input  4  RTC register address
- dato_rtc_in  input  8  RTC write data
- dato_rtc_out  output  8  RTC read data, valid in the ack_rtc cycle
- ack_rtc  output  1  one-cycle completion pulse to RTC
- edicion  input  1  user edit mode; blocks RTC writes to regs 1-6
- alarma  output  1  registered copy of reg 10 bit 0

Behaviour:
- Register map: 1 seg, 2 min, 3 hora, 4 dia, 5 mes, 6 año, 7 alarm seg, 8 alarm min, 9 alarm hora, 10 finalizado, 11 activado, 12 cursor, 13-15 status1-3.
- Reset values: all registers 8'h00 except regs 4 and 5 = RST_DIA_MES. All outputs 0. FSM to IDLE.
- FSM states: IDLE, SRV_RTC, SRV_US, ACK.
- IDLE: if req_rtc=1 go to SRV_RTC; else if req_us=1 go to SRV_US. The RTC port has priority on simultaneous requests.
- SRV_x: samples address, direction and data, performs the access, registers read data and error, then goes to ACK.
- ACK: asserts the ack of the served port for exactly 1 cycle with read data and err_us valid, then returns to IDLE.
- Latency: request seen in IDLE at edge k, ack high during cycle k+2.
- A requester must deassert within 1 cycle after its ack. A request still high in IDLE is treated as a new transaction.
- Consecutive transactions on the same port take a minimum of 3 cycles each.
- BCD write limits (both ports):
  - Regs 1, 2, 7, 8: 00-59.
  - Regs 3, 9: 00-23.
  - Reg 4: 01-31.
  - Reg 5: 01-12.
  - Reg 6: 00-99.
  - Either nibble > 9 is invalid.
  - Out-of-range write: register unchanged; err_us=1 if user port. The RTC port has no err output and the write is silently dropped.
- Permissions:
  - Regs 13-15 are RTC-write-only; a user write is rejected (err_us=1).
  - Reg 10: user may only write 8'h00 (clear); any other user value is rejected.
  - Address 0: reads return 8'h00, writes are ignored, err_us=1.
  - No address >15 exists, since the address is 4 bits wide.
- edicion=1: RTC writes to regs 1-6 are dropped; RTC reads and all other registers are unaffected.
- Reads never alter state and always report err_us=0 for addresses 1-15.
- Alarm compare, evaluated every cycle:
  - Condition: reg11[0]=1 and reg1==reg7 and reg2==reg8 and reg3==reg9.
  - When the condition is true, reg10[0] is set to 1 on the next edge.
  - A user clear of reg10 in the same cycle as a match is overridden: the set wins.
- alarma: registered copy of reg10[0], one cycle behind the register.
- Reset mid-transaction: FSM aborts to IDLE, no ack is issued, and registers return to their reset values.

Test Plan:
- Reset then user read of reg 4 -> ack_us in 3rd cycle after the request, dato_us_out=8'h01, err_us=0. User read of reg 1 -> 8'h00.
- User write reg 2 = 8'h45, then read back -> 8'h45. User write reg 2 = 8'h60 -> err_us=1 and readback still 8'h45. User write reg 3 = 8'h1A -> err_us=1.
- req_us and req_rtc asserted on the same edge -> ack_rtc first, ack_us 3 cycles later, no lost data.
- edicion=1, RTC writes reg 1 = 8'h30 -> reg 1 unchanged. RTC writes reg 13 = 8'hA5 -> applied. User write reg 13 -> err_us=1.
- Program reg7/8/9 = 8'h10/8'h00/8'h00 and reg11 = 8'h01, then RTC writes time 00:00:10 -> alarma=1 two cycles after the completing write. User writes reg10=8'h00 after the seconds change -> alarma=0. User writes reg10=8'h01 -> err_us=1.
- reset driven low during SRV_US -> no ack_us, all registers back to reset values, outputs 0.
